debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised N-channel push-button debouncer, successor to the single-channel key debouncer; sits between raw board inputs (btn/switch pins) and control logic such as UART TX trigger and mode selects.
- All channels share one sample-tick generator; each channel gets a 2-flop synchroniser, a stability counter, a debounced level and one-clock rise/fall pulses.
- An optional auto-repeat pulse supports held keys.

Parameters:
- N_CH, 4, number of independent input channels (1..32).
- TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); simulation uses 4.
- STABLE_CNT, 30, consecutive ticks an input must differ from the current output before the output flips (>=2).
- REPEAT_DELAY, 500, ticks from debounced press to first repeat pulse (repeat build only).
- REPEAT_RATE, 100, ticks between subsequent repeat pulses (repeat build only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn  in  N_CH  raw asynchronous inputs, 1 = pressed.
- key  out  N_CH  debounced level per channel.
- key_rise  out  N_CH  one-clk pulse when key goes 0->1.
- key_fall  out  N_CH  one-clk pulse when key goes 1->0.
- key_rep  out  N_CH  one-clk auto-repeat pulse; constant 0 when feature compiled out.
- tick  out  1  shared sample strobe, exported for reuse and testbench.

Behaviour:
- Reset (rst=0, async): tick counter=0, tick=0, sync flops=0, stability counters=0, key=0, key_rise=0, key_fall=0, key_rep=0, repeat counters=0.
- Tick generator (sub-module): counter runs 0..TICK_DIV-1 and wraps. tick=1 for exactly one clk in the cycle the counter equals TICK_DIV-1. First tick occurs TICK_DIV clks after reset release.
- Synchroniser: btn passes through 2 flops every clk, not only on tick. sync[i] is btn delayed 2 clks.
- Per channel, on tick only:
  - if sync==key: cnt<=0.
  - else if cnt==STABLE_CNT-1: key<=sync, cnt<=0.
  - else cnt<=cnt+1.
- Any tick where sync equals key restarts qualification. A glitch shorter than STABLE_CNT ticks never changes key.
- key_rise/key_fall are registered in the same clk edge that updates key, high for exactly 1 clk. They are never both high on one channel.
- Latency from a clean btn edge to key change is between 2+(STABLE_CNT-1)*TICK_DIV+1 and 2+STABLE_CNT*TICK_DIV clks.
- Counter widths are $clog2 of TICK_DIV and STABLE_CNT, from the package functions. No overflow is possible because cnt saturates by the reset-to-0 rule.
- Channels are fully independent. Simultaneous transitions on several channels in one tick all update in that tick.
- rst asserted mid-qualification discards all state. After release, inputs are requalified from key=0, so a held button produces key_rise STABLE_CNT ticks later.

Optional Feature:
- Macro DEBOUNCE_REPEAT_EN.
- Defined: per-channel repeat counter, cleared whenever key=0 or key_rise fires, incremented on tick while key=1.
  - key_rep pulses for 1 clk (aligned with tick) when the counter reaches REPEAT_DELAY.
  - It then pulses every REPEAT_RATE ticks while key stays 1.
  - key_fall stops repeats in the same cycle.
- Undefined: no repeat logic is synthesised; key_rep is tied to 0; REPEAT_* parameters are ignored.

Decomposition:
- Package debounce_pkg:
  - width function clog2_min1 (returns >=1);
  - default constants TICK_DIV_BOARD=50000 and TICK_DIV_SIM=4;
  - localparam width types for tick and stability counters.
- Sub-module debounce_tick: the shared divider, parameter TICK_DIV, ports clk/rst/tick.
- Per-channel logic is a generate loop, not a separate module.

Test Plan (TICK_DIV=4, STABLE_CNT=3, N_CH=4 unless noted):
- Reset hold then release, btn=0 -> all outputs 0; tick first high 4 clks after release, then every 4 clks.
- btn[0] 0->1 held -> key[0]=1 within 11..14 clks; key_rise[0] high exactly 1 clk; other channels stay 0.
- btn[1] glitch high for 6 clks (<3 ticks) -> key[1] never changes, no pulses; cnt returns to 0.
- btn[2] and btn[3] rise in the same clk -> both key bits and both key_rise bits assert in the same cycle; then release -> single key_fall pulses.
- btn[0] held, rst pulsed low mid-qualification (after 1 tick) -> key[0]=0 immediately; after release, key_rise[0] again after full requalification.
- DEBOUNCE_REPEAT_EN defined, REPEAT_DELAY=5, REPEAT_RATE=2, btn[0] held -> key_rep[0] at tick 5 after key_rise, then every 2 ticks; release -> no key_rep after key_fall. Macro undefined -> key_rep stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared constants and width helpers for the multi-channel debouncer.
//   clog2_min1        : counter width for a modulus, never less than 1 bit
//   TICK_DIV_BOARD    : sample divider for a 50 MHz board clock (1 ms tick)
//   TICK_DIV_SIM      : short divider used when simulating
//   tick_cnt_board_t  : tick counter type at the board divider
//   stable_cnt_default_t : stability counter type at the default qualify length
package debounce_pkg;

  localparam int TICK_DIV_BOARD     = 50000;
  localparam int TICK_DIV_SIM       = 4;
  localparam int STABLE_CNT_DEFAULT = 30;

  // A modulus of 1 still needs a one-bit counter so vectors never collapse to zero width.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    if (value > 1) width = $clog2(value);
    return width;
  endfunction

  localparam int TICK_CNT_W_BOARD     = clog2_min1(TICK_DIV_BOARD);
  localparam int STABLE_CNT_W_DEFAULT = clog2_min1(STABLE_CNT_DEFAULT);

  typedef logic [TICK_CNT_W_BOARD-1:0]     tick_cnt_board_t;
  typedef logic [STABLE_CNT_W_DEFAULT-1:0] stable_cnt_default_t;

endpackage

// File: rtl/debounce_tick.sv
// debounce_tick
// Shared sample-strobe divider. The counter runs 0..TICK_DIV-1 and wraps;
// tick is high for the single clk in which the counter sits at TICK_DIV-1,
// so the first strobe is consumed TICK_DIV clks after reset release.
//   clk  : system clock
//   rst  : asynchronous reset, active low
//   tick : one-clk sample strobe
module debounce_tick
  import debounce_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_BOARD
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W    = clog2_min1(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi
// N-channel push-button debouncer. All channels share one sample strobe; each
// channel has a 2-flop synchroniser, a stability counter, a debounced level and
// registered one-clk rise/fall pulses. A level only flips after the synchronised
// input has differed from it on STABLE_CNT consecutive ticks.
// Optional auto-repeat for held keys is built when DEBOUNCE_REPEAT_EN is defined;
// otherwise key_rep is tied low and REPEAT_DELAY/REPEAT_RATE have no effect.
//   clk      : system clock
//   rst      : asynchronous reset, active low
//   btn      : raw asynchronous inputs, 1 = pressed
//   key      : debounced level per channel
//   key_rise : one-clk pulse on key 0->1
//   key_fall : one-clk pulse on key 1->0
//   key_rep  : one-clk auto-repeat pulse while key is held
//   tick     : shared sample strobe
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = TICK_DIV_BOARD,
  parameter int STABLE_CNT   = STABLE_CNT_DEFAULT,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] key,
  output logic [N_CH-1:0] key_rise,
  output logic [N_CH-1:0] key_fall,
  output logic [N_CH-1:0] key_rep,
  output logic            tick
);

  localparam int               STB_W    = clog2_min1(STABLE_CNT);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CNT - 1);

`ifdef DEBOUNCE_REPEAT_EN
  localparam int               REP_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int               REP_W     = clog2_min1(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE);
`endif

  debounce_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;

  // The synchroniser runs every clk so the sampled value is never stale by more than two clks.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [STB_W-1:0] cnt_q, cnt_d;
    logic             key_q, key_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             flip_now;

    // Any tick on which the input agrees with the level restarts qualification,
    // which also keeps the counter from ever passing STABLE_CNT-1.
    always_comb begin
      cnt_d    = cnt_q;
      key_d    = key_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      flip_now = 1'b0;
      if (tick) begin
        if (sync2_q[i] == key_q) begin
          cnt_d = '0;
        end else if (cnt_q == STB_LAST) begin
          flip_now = 1'b1;
          key_d    = sync2_q[i];
          cnt_d    = '0;
          rise_d   = sync2_q[i];
          fall_d   = ~sync2_q[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q  <= '0;
        key_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        key_q  <= key_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign key[i]      = key_q;
    assign key_rise[i] = rise_q;
    assign key_fall[i] = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [REP_W-1:0] rep_inc;
    logic             rep_armed_q, rep_armed_d;
    logic             rep_q, rep_d;

    // The counter measures ticks since the last pulse (or since the press); the
    // armed flag switches the target from the initial delay to the repeat rate.
    // A tick that drops the key clears the counter instead of pulsing, so no
    // repeat ever lines up with key_fall.
    always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_armed_d = rep_armed_q;
      rep_d       = 1'b0;
      rep_inc     = rep_cnt_q + 1'b1;
      if (!key_q || flip_now) begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
      end else if (tick) begin
        if (rep_inc == (rep_armed_q ? REP_NEXT : REP_FIRST)) begin
          rep_d       = 1'b1;
          rep_cnt_d   = '0;
          rep_armed_d = 1'b1;
        end else begin
          rep_cnt_d = rep_inc;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b0;
        rep_q       <= 1'b0;
      end else begin
        rep_cnt_q   <= rep_cnt_d;
        rep_armed_q <= rep_armed_d;
        rep_q       <= rep_d;
      end
    end

    assign key_rep[i] = rep_q;
`endif
  end

`ifndef DEBOUNCE_REPEAT_EN
  assign key_rep = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi
// Drives debounce_multi with TICK_DIV=4, STABLE_CNT=3, N_CH=4. Expected
// rise/fall/repeat events (cycle, channel, kind) are queued when stimulus is
// applied and popped as the DUT emits pulses; levels and the tick strobe are
// compared directly against values derived from the tick phase.
module tb_debounce_multi;

  localparam int N_CH         = 4;
  localparam int TICK_DIV     = debounce_pkg::TICK_DIV_SIM;
  localparam int STABLE_CNT   = 3;
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_REP  = 2;
  localparam logic [63:0] NO_EVENT = '1;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] key;
  logic [N_CH-1:0] key_rise;
  logic [N_CH-1:0] key_fall;
  logic [N_CH-1:0] key_rep;
  logic            tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] exp_q[$];

  debounce_multi #(
    .N_CH         (N_CH),
    .TICK_DIV     (TICK_DIV),
    .STABLE_CNT   (STABLE_CNT),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .key      (key),
    .key_rise (key_rise),
    .key_fall (key_fall),
    .key_rep  (key_rep),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts clk edges since reset release; edge n has cyc == n afterwards.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] evCode(input int c, input int ch, input int kind);
    return 64'(c) * 64'd16 + 64'(ch * 4 + kind);
  endfunction

  // Edge at which a level change applied just after negedge c lands: the new
  // value is synchronised by edge c+2, so the first tick edge that sees it is the
  // first multiple of TICK_DIV at or after c+3, and STABLE_CNT ticks are needed.
  function automatic int keyEdge(input int c);
    int first_tick;
    first_tick = ((c + 3 + TICK_DIV - 1) / TICK_DIV) * TICK_DIV;
    return first_tick + (STABLE_CNT - 1) * TICK_DIV;
  endfunction

  task automatic expectEvent(input int c, input int ch, input int kind);
    exp_q.push_back(evCode(c, ch, kind));
  endtask

  task automatic scoreEvent(input int ch, input int kind);
    logic [63:0] obs;
    obs = evCode(cyc, ch, kind);
    if (exp_q.size() == 0) checkOutput("evt_unexpected", obs, NO_EVENT);
    else                   checkOutput("evt", obs, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (key_rise[ch] === 1'b1) scoreEvent(ch, K_RISE);
        if (key_fall[ch] === 1'b1) scoreEvent(ch, K_FALL);
        if (key_rep[ch]  === 1'b1) scoreEvent(ch, K_REP);
      end
    end
  end

  task automatic applyStimulus(input logic [N_CH-1:0] value, output int c);
    @(negedge clk);
    #1;
    btn = value;
    c   = cyc;
  endtask

  task automatic waitDrain(input string tag, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    int n;
    int first_tick;
    int k_edge;
    int f_edge;
    int c_r;

    rst = 1'b0;
    btn = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_key",  64'(key),      64'd0);
    checkOutput("rst_rise", 64'(key_rise), 64'd0);
    checkOutput("rst_fall", 64'(key_fall), 64'd0);
    checkOutput("rst_rep",  64'(key_rep),  64'd0);
    checkOutput("rst_tick", 64'(tick),     64'd0);

    #1 rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("tick_phase", 64'(tick), 64'(cyc % TICK_DIV == TICK_DIV - 1));
    end
    checkOutput("idle_key", 64'(key), 64'd0);

    // Single press on channel 0.
    applyStimulus(4'b0001, c);
    expectEvent(keyEdge(c), 0, K_RISE);
    waitDrain("press0_drain", 40);
    checkOutput("press0_key", 64'(key), 64'b0001);

    // Six-clk glitch on channel 1 must not qualify.
    applyStimulus(4'b0011, c);
    repeat (5) @(negedge clk);
    applyStimulus(4'b0001, c);
    repeat (24) @(negedge clk);
    checkOutput("glitch_key", 64'(key), 64'b0001);

    // A real press afterwards must take the full qualification time.
    applyStimulus(4'b0011, c);
    expectEvent(keyEdge(c), 1, K_RISE);
    waitDrain("press1_drain", 40);
    checkOutput("press1_key", 64'(key), 64'b0011);

    applyStimulus(4'b0000, c);
    expectEvent(keyEdge(c), 0, K_FALL);
    expectEvent(keyEdge(c), 1, K_FALL);
    waitDrain("rel01_drain", 40);
    checkOutput("rel01_key", 64'(key), 64'd0);

    // Channels 2 and 3 together.
    applyStimulus(4'b1100, c);
    expectEvent(keyEdge(c), 2, K_RISE);
    expectEvent(keyEdge(c), 3, K_RISE);
    waitDrain("press23_drain", 40);
    checkOutput("press23_key", 64'(key), 64'b1100);

    applyStimulus(4'b0000, c);
    expectEvent(keyEdge(c), 2, K_FALL);
    expectEvent(keyEdge(c), 3, K_FALL);
    waitDrain("rel23_drain", 40);
    checkOutput("rel23_key", 64'(key), 64'd0);

    // Reset after one qualifying tick on a held channel 0.
    applyStimulus(4'b0001, c);
    first_tick = keyEdge(c) - (STABLE_CNT - 1) * TICK_DIV;
    n = 0;
    while (cyc < first_tick + 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_key",  64'(key),      64'd0);
    checkOutput("midrst_rise", 64'(key_rise), 64'd0);
    checkOutput("midrst_tick", 64'(tick),     64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // Held through reset: requalify from zero, then hold long enough to repeat.
    k_edge = keyEdge(0);
    c_r    = 60;
    f_edge = keyEdge(c_r);
    expectEvent(k_edge, 0, K_RISE);
`ifdef DEBOUNCE_REPEAT_EN
    for (int t = k_edge + REPEAT_DELAY * TICK_DIV; t < f_edge; t += REPEAT_RATE * TICK_DIV)
      expectEvent(t, 0, K_REP);
`endif
    expectEvent(f_edge, 0, K_FALL);

    n = 0;
    while (cyc < c_r && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held_key", 64'(key), 64'b0001);
    #1 btn = '0;
    waitDrain("hold_drain", 100);
    checkOutput("hold_rel_key", 64'(key), 64'd0);

    repeat (40) @(negedge clk);
    checkOutput("final_queue", 64'(exp_q.size()), 64'd0);
    checkOutput("final_rep",   64'(key_rep),      64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
